// File: rtl/rf_pkg.sv
// Shared sizing and types for the register file and its load tag FIFO.
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int LD_DEPTH = 2;

  typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/ld_tag_fifo.sv
// In-order FIFO of destination tags for loads still waiting on memory.
// Callers gate push/pop; this block assumes no push when full without a pop, and no pop when empty.
module ld_tag_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = rf_pkg::LD_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  reg_addr_t push_tag,
  output reg_addr_t head_tag,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  reg_addr_t         tags_q [DEPTH];
  reg_addr_t         tags_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (push) tags_d[wr_ptr_q] = push_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) tags_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tags_q   <= tags_d;
    end
  end

  assign head_tag = tags_q[rd_ptr_q];
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with same-cycle write bypass and a per-register load
// scoreboard; returning loads land in the register tagged at issue time.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int XLEN     = rf_pkg::XLEN,
  parameter int NREG     = rf_pkg::NREG,
  parameter int LD_DEPTH = rf_pkg::LD_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  reg_addr_t       wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ld_issue,
  input  reg_addr_t       ld_rd,
  output logic            ld_issue_ready,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  input  reg_addr_t       rs1,
  input  reg_addr_t       rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            operands_ready,
  output logic            ld_err
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [1:0]      pend_q [NREG];
  logic [1:0]      pend_d [NREG];
  logic            err_q, err_d;

  reg_addr_t head_tag;
  logic      fifo_full, fifo_empty;
  logic      push_en, pop_en;
  logic      rs1_ok, rs2_ok;

  // Issue handshake: a load is accepted when ld_issue && ld_issue_ready at the
  // edge; ld_valid is not back-pressured and consumes the FIFO head if any.
  assign ld_issue_ready = !fifo_full || ld_valid;
  assign push_en        = ld_issue && ld_issue_ready;
  assign pop_en         = ld_valid && !fifo_empty;

  ld_tag_fifo #(.DEPTH(LD_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_en),
    .pop      (pop_en),
    .push_tag (ld_rd),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    err_d  = err_q || (ld_valid && fifo_empty) || (ld_issue && !ld_issue_ready);
    for (int r = 1; r < NREG; r++) begin
      if (wb_en && wb_rd == reg_addr_t'(r)) regs_d[r] = wb_data;
      // Load return is applied after WB so it wins on a same-register collision.
      if (pop_en && head_tag == reg_addr_t'(r)) regs_d[r] = ld_data;
      if ((push_en && ld_rd == reg_addr_t'(r)) && !(pop_en && head_tag == reg_addr_t'(r)))
        pend_d[r] = pend_q[r] + 2'd1;
      else if (!(push_en && ld_rd == reg_addr_t'(r)) && (pop_en && head_tag == reg_addr_t'(r)))
        pend_d[r] = pend_q[r] - 2'd1;
    end
    regs_d[0] = '0;
    pend_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
    end else begin
      err_q  <= err_d;
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    if (rs1 == '0)                       rs1_data = '0;
    else if (pop_en && head_tag == rs1)  rs1_data = ld_data;
    else if (wb_en && wb_rd == rs1)      rs1_data = wb_data;
    else                                 rs1_data = regs_q[rs1];

    if (rs2 == '0)                       rs2_data = '0;
    else if (pop_en && head_tag == rs2)  rs2_data = ld_data;
    else if (wb_en && wb_rd == rs2)      rs2_data = wb_data;
    else                                 rs2_data = regs_q[rs2];
  end

  // A single outstanding load returning this cycle is covered by the bypass.
  assign rs1_ok = (pend_q[rs1] == 2'd0) || (pend_q[rs1] == 2'd1 && pop_en && head_tag == rs1);
  assign rs2_ok = (pend_q[rs2] == 2'd0) || (pend_q[rs2] == 2'd1 && pop_en && head_tag == rs2);
  assign operands_ready = rs1_ok && rs2_ok;
  assign ld_err         = err_q;
endmodule
